// File: rtl/paged_mem_cache.sv
// Paged memory cache: NF resident page frames with true-LRU replacement, dirty write-back,
// per-page permissions and a valid/ack backing-store port for misses and flushes.
module paged_mem_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PAGE_BITS  = 10,
  parameter int FRAME_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_exec,
  input  logic              req_priv,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  input  logic              flush,
  output logic              busy,
  output logic              bs_req,
  output logic              bs_we,
  output logic              bs_meta,
  output logic [ADDR_W-1:0] bs_addr,
  output logic [DATA_W-1:0] bs_wdata,
  input  logic              bs_ack,
  input  logic [DATA_W-1:0] bs_rdata
);
  localparam int NF     = 1 << FRAME_BITS;
  localparam int PW     = 1 << PAGE_BITS;
  localparam int VPN_W  = ADDR_W - PAGE_BITS;
  localparam int RAM_AW = FRAME_BITS + PAGE_BITS;
  localparam logic [FRAME_BITS-1:0] LAST_FRAME = FRAME_BITS'(NF - 1);
  localparam logic [PAGE_BITS-1:0]  LAST_OFF   = PAGE_BITS'(PW - 1);

  // Backing-store handshake: bs_req and every bs_* field stay constant from the
  // cycle bs_req rises until the cycle bs_ack=1 completes it; bs_ack without bs_req is ignored.
  typedef enum logic [2:0] {
    S_IDLE, S_WB_DATA, S_WB_META, S_FILL, S_META, S_REPLAY, S_FL_SCAN, S_FL_DONE
  } state_t;
  state_t state_q, state_d;

  logic [NF-1:0]         valid_q, dirty_q;
  logic [VPN_W-1:0]      vpn_q  [NF];
  logic [3:0]            perm_q [NF];
  logic [FRAME_BITS-1:0] rank_q [NF];

  logic                  lat_we, lat_exec, lat_priv;
  logic [VPN_W-1:0]      lat_vpn;
  logic [PAGE_BITS-1:0]  lat_off;
  logic [DATA_W-1:0]     lat_wdata;
  logic [FRAME_BITS-1:0] victim_q, fl_idx_q;
  logic [PAGE_BITS-1:0]  cnt_q;
  logic                  primed_q, flushing_q, resp_rd_q;

  logic [DATA_W-1:0] ram [NF*PW];
  logic [DATA_W-1:0] ram_q;
  logic [RAM_AW-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_we;

  logic                  a_we, a_exec, a_priv;
  logic [VPN_W-1:0]      a_vpn;
  logic [PAGE_BITS-1:0]  a_off;
  logic [DATA_W-1:0]     a_wdata;
  logic                  hit, allowed, do_access, access_ok;
  logic [FRAME_BITS-1:0] hit_idx, vict_idx;
  logic [3:0]            hit_perm;
  logic                  vict_found;

  // The access under evaluation is the live request in IDLE or the latched one on replay.
  always_comb begin
    if (state_q == S_REPLAY) begin
      a_we = lat_we; a_exec = lat_exec; a_priv = lat_priv;
      a_vpn = lat_vpn; a_off = lat_off; a_wdata = lat_wdata;
    end else begin
      a_we = req_we; a_exec = req_exec; a_priv = req_priv;
      a_vpn = req_addr[ADDR_W-1:PAGE_BITS]; a_off = req_addr[PAGE_BITS-1:0];
      a_wdata = req_wdata;
    end
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NF; i++) begin
      if (valid_q[i] && vpn_q[i] == a_vpn) begin
        hit = 1'b1;
        hit_idx = FRAME_BITS'(i);
      end
    end
    hit_perm = perm_q[hit_idx];
    if (a_priv)           allowed = 1'b1;
    else if (hit_perm[3]) allowed = 1'b0;
    else if (a_we)        allowed = hit_perm[1];
    else if (a_exec)      allowed = hit_perm[0];
    else                  allowed = hit_perm[2];
    do_access = hit && ((state_q == S_IDLE && req_valid && !flush) || state_q == S_REPLAY);
    access_ok = do_access && allowed;
  end

  always_comb begin
    vict_found = 1'b0;
    vict_idx = '0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        vict_found = 1'b1;
        vict_idx = FRAME_BITS'(i);
      end
    end
    if (!vict_found) begin
      for (int i = 0; i < NF; i++) begin
        if (rank_q[i] == LAST_FRAME) vict_idx = FRAME_BITS'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    bs_req    = 1'b0;
    bs_we     = 1'b0;
    bs_meta   = 1'b0;
    bs_addr   = '0;
    bs_wdata  = '0;
    rd_addr   = {hit_idx, a_off};
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (flush) state_d = S_FL_SCAN;
        else if (req_valid && !hit)
          state_d = (valid_q[vict_idx] && dirty_q[vict_idx]) ? S_WB_DATA : S_FILL;
      end
      S_WB_DATA: begin
        // Word is read from RAM one cycle before it is offered; ram_q holds it through the stall.
        rd_addr = {victim_q, cnt_q};
        if (primed_q) begin
          bs_req   = 1'b1;
          bs_we    = 1'b1;
          bs_addr  = {vpn_q[victim_q], cnt_q};
          bs_wdata = ram_q;
          if (bs_ack && cnt_q == LAST_OFF) state_d = S_WB_META;
        end
      end
      S_WB_META: begin
        bs_req   = 1'b1;
        bs_we    = 1'b1;
        bs_meta  = 1'b1;
        bs_addr  = {{PAGE_BITS{1'b0}}, vpn_q[victim_q]};
        bs_wdata = {{(DATA_W-4){1'b0}}, perm_q[victim_q]};
        if (bs_ack) begin
          if (!flushing_q)                  state_d = S_FILL;
          else if (fl_idx_q == LAST_FRAME)  state_d = S_FL_DONE;
          else                              state_d = S_FL_SCAN;
        end
      end
      S_FILL: begin
        bs_req  = 1'b1;
        bs_addr = {lat_vpn, cnt_q};
        if (bs_ack && cnt_q == LAST_OFF) state_d = S_META;
      end
      S_META: begin
        bs_req  = 1'b1;
        bs_meta = 1'b1;
        bs_addr = {{PAGE_BITS{1'b0}}, lat_vpn};
        if (bs_ack) state_d = S_REPLAY;
      end
      S_REPLAY: state_d = S_IDLE;
      S_FL_SCAN: begin
        if (valid_q[fl_idx_q] && dirty_q[fl_idx_q]) state_d = S_WB_DATA;
        else if (fl_idx_q == LAST_FRAME)          state_d = S_FL_DONE;
      end
      S_FL_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign resp_rdata = resp_rd_q ? ram_q : '0;
  assign ram_we     = (access_ok && a_we) || (state_q == S_FILL && bs_ack);
  assign wr_addr    = (state_q == S_FILL) ? {victim_q, cnt_q} : {hit_idx, a_off};
  assign wr_data    = (state_q == S_FILL) ? bs_rdata : a_wdata;

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr] <= wr_data;
    ram_q <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < NF; i++) begin
        vpn_q[i]  <= '0;
        perm_q[i] <= '0;
        rank_q[i] <= FRAME_BITS'(i);
      end
      lat_we     <= 1'b0;
      lat_exec   <= 1'b0;
      lat_priv   <= 1'b0;
      lat_vpn    <= '0;
      lat_off    <= '0;
      lat_wdata  <= '0;
      victim_q   <= '0;
      fl_idx_q   <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      flushing_q <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_valid <= do_access;
      resp_fault <= do_access && !allowed;
      resp_rd_q  <= access_ok && !a_we;
      if (access_ok) begin
        if (a_we) dirty_q[hit_idx] <= 1'b1;
        for (int i = 0; i < NF; i++) begin
          if (FRAME_BITS'(i) == hit_idx)         rank_q[i] <= '0;
          else if (rank_q[i] < rank_q[hit_idx])  rank_q[i] <= rank_q[i] + 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            flushing_q <= 1'b1;
            fl_idx_q   <= '0;
          end else if (req_valid && !hit) begin
            lat_we    <= req_we;
            lat_exec  <= req_exec;
            lat_priv  <= req_priv;
            lat_vpn   <= req_addr[ADDR_W-1:PAGE_BITS];
            lat_off   <= req_addr[PAGE_BITS-1:0];
            lat_wdata <= req_wdata;
            victim_q  <= vict_idx;
            cnt_q     <= '0;
            primed_q  <= 1'b0;
          end
        end
        S_WB_DATA: begin
          if (!primed_q) primed_q <= 1'b1;
          else if (bs_ack) begin
            primed_q <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        S_WB_META: begin
          if (bs_ack && flushing_q && fl_idx_q != LAST_FRAME) fl_idx_q <= fl_idx_q + 1'b1;
        end
        S_FILL: begin
          if (bs_ack) cnt_q <= cnt_q + 1'b1;
        end
        S_META: begin
          if (bs_ack) begin
            valid_q[victim_q] <= 1'b1;
            dirty_q[victim_q] <= 1'b0;
            vpn_q[victim_q]   <= lat_vpn;
            perm_q[victim_q]  <= bs_rdata[3:0];
          end
        end
        S_FL_SCAN: begin
          if (valid_q[fl_idx_q] && dirty_q[fl_idx_q]) begin
            victim_q <= fl_idx_q;
            cnt_q    <= '0;
            primed_q <= 1'b0;
          end else if (fl_idx_q != LAST_FRAME) begin
            fl_idx_q <= fl_idx_q + 1'b1;
          end
        end
        S_FL_DONE: begin
          valid_q    <= '0;
          dirty_q    <= '0;
          flushing_q <= 1'b0;
          for (int i = 0; i < NF; i++) rank_q[i] <= FRAME_BITS'(i);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_paged_mem_cache.sv
// Bench for paged_mem_cache: directed scenarios plus random traffic checked against a
// page-level reference model (MRU-ordered frame list, word arrays, backing-store image).
module tb_paged_mem_cache;
  localparam int NF = 2;
  localparam int PW = 4;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_exec, req_priv;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        flush, busy;
  logic        bs_req, bs_we, bs_meta, bs_ack;
  logic [31:0] bs_addr, bs_wdata, bs_rdata;

  paged_mem_cache #(.ADDR_W(32), .DATA_W(32), .PAGE_BITS(2), .FRAME_BITS(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_exec(req_exec), .req_priv(req_priv), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .flush(flush), .busy(busy), .bs_req(bs_req), .bs_we(bs_we), .bs_meta(bs_meta),
    .bs_addr(bs_addr), .bs_wdata(bs_wdata), .bs_ack(bs_ack), .bs_rdata(bs_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- counters and checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [65:0] pack(input bit w, input bit m, input logic [31:0] a,
                                       input logic [31:0] d);
    return {w, m, a, (w ? d : 32'h0)};
  endfunction

  // ---------------- backing-store responder ----------------
  logic [31:0] bs_mem [logic [31:0]];
  logic [3:0]  bs_meta_tab [logic [29:0]];
  logic [65:0] act_q [$];
  int          ack_delay = 0;
  bit          spur = 0;
  int          wait_cnt = 0;
  bit          holding = 0;
  logic [65:0] held;

  function automatic logic [31:0] bs_mem_rd(input logic [31:0] a);
    if (bs_mem.exists(a)) return bs_mem[a];
    return a;
  endfunction

  function automatic logic [3:0] bs_meta_rd(input logic [29:0] v);
    if (bs_meta_tab.exists(v)) return bs_meta_tab[v];
    return 4'hF;
  endfunction

  always @(negedge clk) begin
    logic [65:0] raw;
    bs_ack   = 1'b0;
    bs_rdata = 32'h0;
    if (bs_req) begin
      raw = {bs_we, bs_meta, bs_addr, bs_wdata};
      if (holding) check("bs_stable", raw, held);
      else begin
        held = raw;
        holding = 1;
      end
      if (wait_cnt >= ack_delay) begin
        bs_ack   = 1'b1;
        wait_cnt = 0;
        holding  = 0;
        if (bs_we) begin
          if (bs_meta) bs_meta_tab[bs_addr[29:0]] = bs_wdata[3:0];
          else         bs_mem[bs_addr] = bs_wdata;
        end else begin
          bs_rdata = bs_meta ? {28'h0, bs_meta_rd(bs_addr[29:0])} : bs_mem_rd(bs_addr);
        end
        act_q.push_back(pack(bs_we, bs_meta, bs_addr, bs_wdata));
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      holding  = 0;
      if (spur && $urandom_range(0, 3) == 0) begin
        bs_ack   = 1'b1;
        bs_rdata = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  bit          m_valid [NF];
  logic [29:0] m_vpn   [NF];
  bit          m_dirty [NF];
  logic [3:0]  m_perm  [NF];
  logic [31:0] m_data  [NF][PW];
  int          m_lru [$];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [3:0]  ref_meta [logic [29:0]];
  logic [65:0] exp_q [$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a;
  endfunction

  function automatic logic [3:0] ref_meta_rd(input logic [29:0] v);
    if (ref_meta.exists(v)) return ref_meta[v];
    return 4'hF;
  endfunction

  function automatic bit perm_ok(input logic [3:0] p, input bit we, input bit ex, input bit pv);
    if (pv)   return 1'b1;
    if (p[3]) return 1'b0;
    if (we)   return p[1];
    if (ex)   return p[0];
    return p[2];
  endfunction

  task automatic model_reset();
    m_lru.delete();
    for (int i = 0; i < NF; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_perm[i]  = 4'h0;
      m_lru.push_back(i);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic touch(input int fr);
    for (int k = 0; k < m_lru.size(); k++) begin
      if (m_lru[k] == fr) begin
        m_lru.delete(k);
        break;
      end
    end
    m_lru.push_front(fr);
  endtask

  task automatic model_writeback(input int fr);
    logic [31:0] a;
    for (int o = 0; o < PW; o++) begin
      a = {m_vpn[fr], 2'(o)};
      exp_q.push_back(pack(1, 0, a, m_data[fr][o]));
      ref_mem[a] = m_data[fr][o];
    end
    exp_q.push_back(pack(1, 1, {2'b00, m_vpn[fr]}, {28'h0, m_perm[fr]}));
    ref_meta[m_vpn[fr]] = m_perm[fr];
  endtask

  task automatic model_req(input bit we, input bit ex, input bit pv, input logic [31:0] addr,
                           input logic [31:0] wd, output bit f, output logic [31:0] rd,
                           output bit was_hit);
    logic [29:0] vpn;
    int          off, fr;
    logic [31:0] a;
    vpn = addr[31:2];
    off = int'(addr[1:0]);
    fr  = -1;
    for (int i = 0; i < NF; i++) if (m_valid[i] && m_vpn[i] == vpn) fr = i;
    was_hit = (fr >= 0);
    if (!was_hit) begin
      for (int i = NF - 1; i >= 0; i--) if (!m_valid[i]) fr = i;
      if (fr < 0) fr = m_lru[NF-1];
      if (m_valid[fr] && m_dirty[fr]) model_writeback(fr);
      for (int o = 0; o < PW; o++) begin
        a = {vpn, 2'(o)};
        exp_q.push_back(pack(0, 0, a, 32'h0));
        m_data[fr][o] = ref_rd(a);
      end
      exp_q.push_back(pack(0, 1, {2'b00, vpn}, 32'h0));
      m_perm[fr]  = ref_meta_rd(vpn);
      m_valid[fr] = 1;
      m_dirty[fr] = 0;
      m_vpn[fr]   = vpn;
    end
    rd = 32'h0;
    f  = 1'b1;
    if (perm_ok(m_perm[fr], we, ex, pv)) begin
      f = 1'b0;
      if (we) begin
        m_data[fr][off] = wd;
        m_dirty[fr] = 1;
      end else begin
        rd = m_data[fr][off];
      end
      touch(fr);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < NF; i++) if (m_valid[i] && m_dirty[i]) model_writeback(i);
    m_lru.delete();
    for (int i = 0; i < NF; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_lru.push_back(i);
    end
  endtask

  task automatic set_meta(input logic [29:0] v, input logic [3:0] p);
    bs_meta_tab[v] = p;
    ref_meta[v] = p;
  endtask

  // ---------------- driver tasks ----------------
  bit          last_fault;
  logic [31:0] last_rdata;
  int          last_lat;

  task automatic compare_bs(input string tag);
    check({tag, "_count"}, 66'(act_q.size()), 66'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) check(tag, act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (!req_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input bit we, input bit ex, input bit pv, input logic [31:0] addr,
                        input logic [31:0] wd);
    bit          ef, was_hit;
    logic [31:0] erd;
    int          lat;
    model_req(we, ex, pv, addr, wd, ef, erd, was_hit);
    @(negedge clk);
    wait_idle();
    req_valid = 1'b1; req_we = we; req_exec = ex; req_priv = pv;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_exec = 1'b0; req_wdata = 32'h0;
    lat = 1;
    while (!resp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 0, 1);
      return;
    end
    last_fault = resp_fault;
    last_rdata = resp_rdata;
    last_lat   = lat;
    check("resp_fault", resp_fault, ef);
    check("resp_rdata", resp_rdata, erd);
    if (was_hit) check("hit_latency", 66'(lat), 1);
    compare_bs("bs_seq");
  endtask

  task automatic do_flush();
    int cyc;
    bit saw_resp;
    model_flush();
    @(negedge clk);
    wait_idle();
    flush = 1'b1;
    @(posedge clk);
    #1 check("flush_busy", busy, 1);
    @(negedge clk);
    flush = 1'b0;
    cyc = 0;
    saw_resp = 0;
    while (busy && cyc < 3000) begin
      if (resp_valid) saw_resp = 1;
      @(negedge clk);
      cyc++;
    end
    check("flush_done", busy, 0);
    check("flush_no_resp", saw_resp, 0);
    compare_bs("flush_seq");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_lat;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_exec = 1'b0; req_priv = 1'b1;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bs_req", bs_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_fault", resp_fault, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b0;

    // cold miss then a hit in the same page
    do_req(0, 0, 1, 32'h0, 32'h0);
    do_req(0, 0, 1, 32'h3, 32'h0);
    check("t1_hit_data", last_rdata, 32'h3);

    // dirty victim is written back before the fill
    do_req(1, 0, 1, 32'h5, 32'hAA);
    do_req(0, 0, 1, 32'h9, 32'h0);
    do_req(0, 0, 1, 32'hD, 32'h0);
    check("t2_wb_word", bs_mem_rd(32'h5), 32'hAA);
    check("t2_wb_meta", bs_meta_rd(30'h1), 4'hF);

    // read-only page
    do_reset();
    set_meta(30'h2, 4'h4);
    do_req(1, 0, 0, 32'h8, 32'h55);
    check("t3_wr_fault", last_fault, 1);
    do_req(0, 1, 0, 32'h8, 32'h0);
    check("t3_exec_fault", last_fault, 1);
    do_req(0, 0, 0, 32'h8, 32'h0);
    check("t3_read_data", last_rdata, 32'h8);

    // elevated-only page
    set_meta(30'h3, 4'h8);
    do_req(0, 0, 0, 32'hC, 32'h0);
    check("t4_user_fault", last_fault, 1);
    do_req(0, 0, 1, 32'hC, 32'h0);
    check("t4_priv_data", last_rdata, 32'hC);

    // stalled acks stretch the miss; reset mid-fill abandons it
    do_reset();
    ack_delay = 0;
    do_req(0, 0, 1, 32'h10, 32'h0);
    base_lat = last_lat;
    do_reset();
    ack_delay = 3;
    do_req(0, 0, 1, 32'h10, 32'h0);
    check("t5_stall_scaled", (last_lat >= 20 && last_lat > base_lat), 1);
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_exec = 1'b0; req_priv = 1'b1; req_addr = 32'h14;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_in_fill", bs_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 check("t5_abort_bs_req", bs_req, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ack_delay = 0;
    do_req(0, 0, 1, 32'h14, 32'h0);
    check("t5_refetch_data", last_rdata, 32'h14);

    // flush of two dirty frames
    do_reset();
    do_req(1, 0, 1, 32'h0, 32'h11);
    do_req(1, 0, 1, 32'hC, 32'h22);
    do_flush();
    do_req(0, 0, 1, 32'h0, 32'h0);
    check("t6_after_flush", last_rdata, 32'h11);

    // random traffic
    do_reset();
    for (int v = 0; v < 6; v++) set_meta(30'(v), 4'($urandom_range(0, 15)));
    spur = 1;
    for (int n = 0; n < 250; n++) begin
      bit we, ex, pv;
      logic [31:0] a;
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        ack_delay = $urandom_range(0, 2);
        we = 1'($urandom_range(0, 1));
        ex = we ? 1'b0 : 1'($urandom_range(0, 1));
        pv = 1'($urandom_range(0, 1));
        a  = {$urandom_range(0, 5), 2'b00} | 32'($urandom_range(0, 3));
        do_req(we, ex, pv, a, $urandom);
      end
    end
    spur = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
